// File: rtl/hazard_dest_scheduler.sv
// ---------------------------------------------------------------------------
// hazard_dest_scheduler
//
// Purpose:
//   Follows the destination register of each instruction through the EX, MEM
//   and WB stages of a 5-stage pipeline. The EX destination is taken from the
//   rt/rd dest mux as the instruction leaves ID. The block also detects
//   load-use hazards, produces the stall and flush controls for the front end,
//   and produces the EX operand forwarding selects.
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   id_*           decoded fields of the instruction currently in ID
//   ex_branch_tk   branch resolved taken in EX this cycle
//   mem_wait       data memory not ready; the whole pipe freezes
//   stall          hold PC and IF/ID
//   flush          clear IF/ID
//   ex_regdst      registered dest-mux select of the EX instruction
//   fwd_a, fwd_b   EX operand sources: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   wb_dest        destination register of the WB instruction
//   wb_we          register-file write enable of the WB instruction
// ---------------------------------------------------------------------------
module hazard_dest_scheduler #(
    parameter int REG_W    = 5,
    parameter int ZERO_REG = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_uses_rt,
    input  logic             id_regdst,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             ex_branch_tk,
    input  logic             mem_wait,
    output logic             stall,
    output logic             flush,
    output logic             ex_regdst,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [REG_W-1:0] wb_dest,
    output logic             wb_we
);

    localparam logic [REG_W-1:0] ZERO = REG_W'(ZERO_REG);

    // EX stage state
    logic             ex_v_q,      ex_v_d;
    logic             ex_wr_q,     ex_wr_d;
    logic             ex_mr_q,     ex_mr_d;
    logic             ex_regdst_q, ex_regdst_d;
    logic [REG_W-1:0] ex_dest_q,   ex_dest_d;
    logic [REG_W-1:0] ex_rs_q,     ex_rs_d;
    logic [REG_W-1:0] ex_rt_q,     ex_rt_d;

    // MEM stage state. Whether the MEM instruction is a load is not tracked:
    // nothing downstream of EX needs it.
    logic             mem_v_q,     mem_v_d;
    logic             mem_wr_q,    mem_wr_d;
    logic [REG_W-1:0] mem_dest_q,  mem_dest_d;

    // WB stage state
    logic             wb_v_q,      wb_v_d;
    logic             wb_wr_q,     wb_wr_d;
    logic [REG_W-1:0] wb_dest_q,   wb_dest_d;

    logic             load_use;
    logic [REG_W-1:0] id_dest;

    // Forwarding source for one EX operand. The MEM match is tested first,
    // so the most recent producer wins. A bubble in EX never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic             ex_v,
        input logic [REG_W-1:0] src,
        input logic             m_v,
        input logic             m_wr,
        input logic [REG_W-1:0] m_dest,
        input logic             w_v,
        input logic             w_wr,
        input logic [REG_W-1:0] w_dest
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (ex_v) begin
            if (m_v && m_wr && (m_dest != ZERO) && (m_dest == src)) begin
                sel = 2'b10;
            end else if (w_v && w_wr && (w_dest != ZERO) && (w_dest == src)) begin
                sel = 2'b01;
            end
        end
        return sel;
    endfunction

    // Hazard detection and next-state selection. mem_wait freezes every
    // stage. A taken branch or a load-use hazard injects a bubble into EX
    // while the older instructions keep draining. The branch case takes
    // priority, so a hazard against a squashed instruction never stalls.
    always_comb begin
        id_dest  = id_regdst ? id_rd : id_rt;
        load_use = id_valid && ex_v_q && ex_mr_q && (ex_dest_q != ZERO) &&
                   ((ex_dest_q == id_rs) || (id_uses_rt && (ex_dest_q == id_rt)));

        ex_v_d      = ex_v_q;
        ex_wr_d     = ex_wr_q;
        ex_mr_d     = ex_mr_q;
        ex_regdst_d = ex_regdst_q;
        ex_dest_d   = ex_dest_q;
        ex_rs_d     = ex_rs_q;
        ex_rt_d     = ex_rt_q;
        mem_v_d     = mem_v_q;
        mem_wr_d    = mem_wr_q;
        mem_dest_d  = mem_dest_q;
        wb_v_d      = wb_v_q;
        wb_wr_d     = wb_wr_q;
        wb_dest_d   = wb_dest_q;

        if (!mem_wait) begin
            wb_v_d     = mem_v_q;
            wb_wr_d    = mem_wr_q;
            wb_dest_d  = mem_dest_q;
            mem_v_d    = ex_v_q;
            mem_wr_d   = ex_wr_q;
            mem_dest_d = ex_dest_q;
            if (ex_branch_tk || load_use || !id_valid) begin
                ex_v_d      = 1'b0;
                ex_wr_d     = 1'b0;
                ex_mr_d     = 1'b0;
                ex_regdst_d = 1'b0;
                ex_dest_d   = ZERO;
                ex_rs_d     = ZERO;
                ex_rt_d     = ZERO;
            end else begin
                ex_v_d      = 1'b1;
                ex_wr_d     = id_regwrite;
                ex_mr_d     = id_memread;
                ex_regdst_d = id_regdst;
                ex_dest_d   = id_dest;
                ex_rs_d     = id_rs;
                ex_rt_d     = id_rt;
            end
        end
    end

    // Stage registers; reset empties the whole pipe at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_v_q      <= 1'b0;
            ex_wr_q     <= 1'b0;
            ex_mr_q     <= 1'b0;
            ex_regdst_q <= 1'b0;
            ex_dest_q   <= ZERO;
            ex_rs_q     <= ZERO;
            ex_rt_q     <= ZERO;
            mem_v_q     <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_dest_q  <= ZERO;
            wb_v_q      <= 1'b0;
            wb_wr_q     <= 1'b0;
            wb_dest_q   <= ZERO;
        end else begin
            ex_v_q      <= ex_v_d;
            ex_wr_q     <= ex_wr_d;
            ex_mr_q     <= ex_mr_d;
            ex_regdst_q <= ex_regdst_d;
            ex_dest_q   <= ex_dest_d;
            ex_rs_q     <= ex_rs_d;
            ex_rt_q     <= ex_rt_d;
            mem_v_q     <= mem_v_d;
            mem_wr_q    <= mem_wr_d;
            mem_dest_q  <= mem_dest_d;
            wb_v_q      <= wb_v_d;
            wb_wr_q     <= wb_wr_d;
            wb_dest_q   <= wb_dest_d;
        end
    end

    // Front-end controls. They are gated by rst_n so that they read 0 during
    // reset even if mem_wait or a branch happens to be asserted.
    always_comb begin
        stall = rst_n && (mem_wait || (!ex_branch_tk && load_use));
        flush = rst_n && !mem_wait && ex_branch_tk;
    end

    always_comb begin
        fwd_a = fwd_sel(ex_v_q, ex_rs_q, mem_v_q, mem_wr_q, mem_dest_q,
                        wb_v_q, wb_wr_q, wb_dest_q);
        fwd_b = fwd_sel(ex_v_q, ex_rt_q, mem_v_q, mem_wr_q, mem_dest_q,
                        wb_v_q, wb_wr_q, wb_dest_q);
    end

    assign ex_regdst = ex_regdst_q;
    assign wb_dest   = wb_dest_q;
    assign wb_we     = wb_v_q && wb_wr_q;

endmodule

// File: tb/tb_hazard_dest_scheduler.sv
// ---------------------------------------------------------------------------
// tb_hazard_dest_scheduler
//
// Purpose:
//   Drives hazard_dest_scheduler with directed scenarios and random traffic.
//   A reference model keeps the three in-flight instructions in a small
//   array and shifts them along each clock. The model's predicted outputs
//   are compared with the DUT on every falling edge. Hand-computed literal
//   checks in the directed scenarios pin the model itself.
// ---------------------------------------------------------------------------
module tb_hazard_dest_scheduler;

    typedef struct packed {
        logic       v;
        logic       we;
        logic       mr;
        logic       regdst;
        logic [4:0] dest;
        logic [4:0] rs;
        logic [4:0] rt;
    } stage_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_uses_rt, id_regdst, id_regwrite, id_memread;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       ex_branch_tk, mem_wait;
    logic       stall, flush, ex_regdst, wb_we;
    logic [1:0] fwd_a, fwd_b;
    logic [4:0] wb_dest;

    // Model pipe: index 0 = EX, 1 = MEM, 2 = WB
    stage_t pipe [3];
    int     n_checks = 0;
    int     n_errors = 0;

    hazard_dest_scheduler #(.REG_W(5), .ZERO_REG(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_uses_rt(id_uses_rt), .id_regdst(id_regdst),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .ex_branch_tk(ex_branch_tk), .mem_wait(mem_wait),
        .stall(stall), .flush(flush), .ex_regdst(ex_regdst),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .wb_dest(wb_dest), .wb_we(wb_we)
    );

    always #5 clk = ~clk;

    // Watchdog so a broken run still terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("[TB] FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 3; i++) pipe[i] = '0;
    endfunction

    function automatic bit model_lu();
        return id_valid && pipe[0].v && pipe[0].mr && pipe[0].dest != 0 &&
               (pipe[0].dest == id_rs || (id_uses_rt && pipe[0].dest == id_rt));
    endfunction

    function automatic int model_fwd(input logic [4:0] src);
        if (!pipe[0].v) return 0;
        if (pipe[1].v && pipe[1].we && pipe[1].dest != 0 && pipe[1].dest == src) return 2;
        if (pipe[2].v && pipe[2].we && pipe[2].dest != 0 && pipe[2].dest == src) return 1;
        return 0;
    endfunction

    // Compare every DUT output against the model for the current cycle.
    task automatic checkOutput();
        int exp_stall, exp_flush;
        if (!rst_n) begin
            exp_stall = 0;
            exp_flush = 0;
        end else begin
            exp_stall = (mem_wait || (!ex_branch_tk && model_lu())) ? 1 : 0;
            exp_flush = (!mem_wait && ex_branch_tk) ? 1 : 0;
        end
        chk("stall", int'(stall), exp_stall);
        chk("flush", int'(flush), exp_flush);
        chk("fwd_a", int'(fwd_a), model_fwd(pipe[0].rs));
        chk("fwd_b", int'(fwd_b), model_fwd(pipe[0].rt));
        chk("wb_we", int'(wb_we), int'(pipe[2].v && pipe[2].we));
        if (pipe[2].v || !rst_n) chk("wb_dest", int'(wb_dest), int'(pipe[2].dest));
        if (pipe[0].v || !rst_n) chk("ex_regdst", int'(ex_regdst), int'(pipe[0].regdst));
    endtask

    // One clock: check at the falling edge, advance the model across the
    // rising edge, then leave time #1 after the edge for new stimulus.
    task automatic tick();
        stage_t nxt [3];
        @(negedge clk);
        checkOutput();
        nxt = pipe;
        if (rst_n && !mem_wait) begin
            nxt[2] = pipe[1];
            nxt[1] = pipe[0];
            if (ex_branch_tk || model_lu() || !id_valid) begin
                nxt[0] = '0;
            end else begin
                nxt[0].v      = 1'b1;
                nxt[0].we     = id_regwrite;
                nxt[0].mr     = id_memread;
                nxt[0].regdst = id_regdst;
                nxt[0].dest   = id_regdst ? id_rd : id_rt;
                nxt[0].rs     = id_rs;
                nxt[0].rt     = id_rt;
            end
        end
        @(posedge clk);
        pipe = nxt;
        #1;
    endtask

    task automatic applyStimulus(input bit v, input int rs, input int rt, input int rd,
                                 input bit uses_rt, input bit regdst, input bit we,
                                 input bit mr, input bit br, input bit mw);
        id_valid     = v;
        id_rs        = 5'(rs);
        id_rt        = 5'(rt);
        id_rd        = 5'(rd);
        id_uses_rt   = uses_rt;
        id_regdst    = regdst;
        id_regwrite  = we;
        id_memread   = mr;
        ex_branch_tk = br;
        mem_wait     = mw;
    endtask

    task automatic bubble();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        bubble();
        repeat (3) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        bubble();
        model_clear();
        repeat (2) tick();
        rst_n = 1'b1;

        // Dest mux: regdst=1 selects rd, regdst=0 selects rt
        applyStimulus(1, 1, 5, 9, 0, 1, 1, 0, 0, 0);
        tick();
        #1 chk("lit_ex_regdst_1", int'(ex_regdst), 1);
        bubble();
        tick();
        tick();
        #1 chk("lit_wb_dest_rd", int'(wb_dest), 9);
        chk("lit_wb_we_rd", int'(wb_we), 1);
        applyStimulus(1, 1, 5, 9, 0, 0, 1, 0, 0, 0);
        tick();
        bubble();
        tick();
        tick();
        #1 chk("lit_wb_dest_rt", int'(wb_dest), 5);
        drain();

        // Load-use: lw $8 then add rs=8; one stall, then MEM/WB forward
        applyStimulus(1, 0, 8, 0, 0, 0, 1, 1, 0, 0);
        tick();
        applyStimulus(1, 8, 2, 10, 1, 1, 1, 0, 0, 0);
        #1 chk("lit_lu_stall", int'(stall), 1);
        tick();
        #1 chk("lit_lu_stall_once", int'(stall), 0);
        tick();
        bubble();
        #1 chk("lit_lu_fwd_a", int'(fwd_a), 1);
        chk("lit_lu_fwd_b", int'(fwd_b), 0);
        drain();

        // Forward priority: two writers of $3, MEM wins
        applyStimulus(1, 1, 2, 3, 1, 1, 1, 0, 0, 0);
        tick();
        applyStimulus(1, 4, 5, 3, 1, 1, 1, 0, 0, 0);
        tick();
        applyStimulus(1, 3, 3, 7, 1, 1, 1, 0, 0, 0);
        tick();
        #1 chk("lit_prio_fwd_a", int'(fwd_a), 2);
        chk("lit_prio_fwd_b", int'(fwd_b), 2);
        // Writes to $0 never forward
        applyStimulus(1, 1, 2, 0, 1, 1, 1, 0, 0, 0);
        tick();
        applyStimulus(1, 0, 0, 6, 1, 1, 1, 0, 0, 0);
        tick();
        #1 chk("lit_zero_fwd_a", int'(fwd_a), 0);
        chk("lit_zero_fwd_b", int'(fwd_b), 0);
        drain();

        // Taken branch overrides a load-use hazard
        applyStimulus(1, 0, 8, 0, 0, 0, 1, 1, 0, 0);
        tick();
        applyStimulus(1, 8, 0, 4, 0, 1, 1, 0, 1, 0);
        #1 chk("lit_br_flush", int'(flush), 1);
        chk("lit_br_stall", int'(stall), 0);
        tick();
        applyStimulus(1, 8, 0, 4, 0, 1, 1, 0, 0, 0);
        #1 chk("lit_br_no_stall", int'(stall), 0);
        tick();
        drain();

        // mem_wait for 3 cycles over a lw/use pair
        applyStimulus(1, 0, 8, 0, 0, 0, 1, 1, 0, 0);
        tick();
        applyStimulus(1, 8, 0, 4, 0, 1, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            #1 chk("lit_mw_stall", int'(stall), 1);
            tick();
        end
        mem_wait = 1'b0;
        #1 chk("lit_mw_lu_stall", int'(stall), 1);
        tick();
        #1 chk("lit_mw_after", int'(stall), 0);
        tick();
        bubble();
        #1 chk("lit_mw_fwd_a", int'(fwd_a), 1);
        tick();

        // Asynchronous reset mid-stream, then independent traffic
        applyStimulus(1, 1, 2, 11, 1, 1, 1, 0, 0, 0);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        model_clear();
        chk("lit_rst_wb_we", int'(wb_we), 0);
        chk("lit_rst_wb_dest", int'(wb_dest), 0);
        chk("lit_rst_ex_regdst", int'(ex_regdst), 0);
        chk("lit_rst_fwd_a", int'(fwd_a), 0);
        chk("lit_rst_stall", int'(stall), 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 20 + i, 26, 12 + i, 1, 1, 1, 1, 0, 0);
            #1 chk("lit_post_rst_stall", int'(stall), 0);
            tick();
        end

        // Random traffic on a small register window to provoke hazards
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 99) < 85,
                          $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 35,
                          $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 12);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
